// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: round-robin 16-way grant FSM with hold timeout and inter-grant gap
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req[15:0]      request bits, one per requester
//   done           release strobe from the current holder (ignored outside GRANT)
//   gnt_en         enable for the downstream 4-to-16 decode
//   gnt_idx[3:0]   binary index of the granted requester, holds while gnt_en=0
//   gnt[15:0]      one-hot grant, zero when gnt_en=0
//   busy           high in GRANT and GAP
//   timeout        one-cycle pulse on a forced release
module rr_grant_sequencer #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic        gnt_en,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  state_e      state_q;
  logic [3:0]  ptr_q, gnt_idx_q, win_d;
  logic [7:0]  hcnt_q;
  logic [15:0] gnt_q;
  logic        gnt_en_q, busy_q, timeout_q, release_d, expire_d;
  // Scan downward so the lowest offset from ptr_q is the last (winning) assignment.
  always_comb begin
    win_d = ptr_q;
    for (int i = 15; i >= 0; i--)
      if (req[ptr_q + 4'(i)]) win_d = ptr_q + 4'(i);
  end
  assign release_d = done | ~req[gnt_idx_q];
  assign expire_d  = hcnt_q == 8'(HOLD_MAX - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      hcnt_q    <= '0;
      gnt_q     <= '0;
      gnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          state_q   <= GRANT;
          gnt_en_q  <= 1'b1;
          gnt_idx_q <= win_d;
          gnt_q     <= 16'd1 << win_d;
          ptr_q     <= win_d + 4'd1;
          hcnt_q    <= '0;
          busy_q    <= 1'b1;
        end
        GRANT: if (release_d || expire_d) begin
          state_q   <= GAP;
          gnt_en_q  <= 1'b0;
          gnt_q     <= '0;
          // A normal release on the expiry cycle wins over the forced one.
          timeout_q <= ~release_d;
        end else begin
          hcnt_q    <= hcnt_q + 8'd1;
        end
        GAP: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt_en  = gnt_en_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule
